// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) control FSM: sequences fetch/decode/execute/mem/writeback and
// decodes datapath controls from the current state and the latched instruction register.
module multicycle_control_unit #(
    parameter int unsigned ENABLE_M  = 0,
    parameter int unsigned TRAP_HALT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        ifetch_req,
    input  logic        ifetch_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        muldiv_start,
    input  logic        muldiv_done,
    output logic [2:0]  muldiv_op,
    output logic        pc_write,
    output logic        register_enable_write,
    output logic        alu_src,
    output logic        alu_src_a_pc,
    output logic [3:0]  alu_control,
    output logic [1:0]  wb_select,
    output logic        muldiv_sel,
    output logic [1:0]  next_pc_select,
    output logic [1:0]  memory_size,
    output logic        memory_sign_ext,
    output logic        illegal_instr,
    output logic        retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StMuldiv    = 3'd6,
        StTrap      = 3'd7
    } state_e;

    localparam logic [6:0]  OpR      = 7'b0110011;
    localparam logic [6:0]  OpImm    = 7'b0010011;
    localparam logic [6:0]  OpLoad   = 7'b0000011;
    localparam logic [6:0]  OpStore  = 7'b0100011;
    localparam logic [6:0]  OpBranch = 7'b1100011;
    localparam logic [6:0]  OpJal    = 7'b1101111;
    localparam logic [6:0]  OpJalr   = 7'b1100111;
    localparam logic [6:0]  OpLui    = 7'b0110111;
    localparam logic [6:0]  OpAuipc  = 7'b0010111;
    localparam logic [31:0] Nop      = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    logic        ill_q;
    logic        md_busy_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_rs;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign rd        = ir_q[11:7];
    assign unused_rs = ^ir_q[24:15];

    logic       legal, is_mop, is_load, is_store, is_branch, is_jal, is_jalr;
    logic [3:0] dec_alu;
    logic       dec_src, dec_apc;
    logic [1:0] dec_wb;

    // alt selects SUB/SRA over ADD/SRL for the same funct3
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? 4'b0001 : 4'b0000;
            3'b001:  op = 4'b0010;
            3'b010:  op = 4'b0011;
            3'b011:  op = 4'b0100;
            3'b100:  op = 4'b0101;
            3'b101:  op = alt ? 4'b0111 : 4'b0110;
            3'b110:  op = 4'b1000;
            default: op = 4'b1001;
        endcase
        return op;
    endfunction

    always_comb begin
        legal     = 1'b0;
        is_mop    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        dec_alu   = 4'b0000;
        dec_src   = 1'b0;
        dec_apc   = 1'b0;
        dec_wb    = 2'b00;
        case (opcode)
            OpR: begin
                if (funct7 == 7'b0000000) begin
                    legal   = 1'b1;
                    dec_alu = alu_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal   = 1'b1;
                    dec_alu = alu_op(funct3, 1'b1);
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    legal  = 1'b1;
                    is_mop = 1'b1;
                end
            end
            OpImm: begin
                dec_src = 1'b1;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    legal = 1'b1;
                end
                dec_alu = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OpLoad: begin
                legal   = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                is_load = 1'b1;
                dec_src = 1'b1;
                dec_wb  = 2'b01;
            end
            OpStore: begin
                legal    = !funct3[2] && (funct3[1:0] != 2'b11);
                is_store = 1'b1;
                dec_src  = 1'b1;
            end
            OpBranch: begin
                legal     = (funct3[2:1] != 2'b01);
                is_branch = 1'b1;
                dec_alu   = 4'b0001;
            end
            OpJal: begin
                legal  = 1'b1;
                is_jal = 1'b1;
                dec_wb = 2'b10;
            end
            OpJalr: begin
                legal   = (funct3 == 3'b000);
                is_jalr = 1'b1;
                dec_src = 1'b1;
                dec_wb  = 2'b10;
            end
            OpLui: begin
                legal  = 1'b1;
                dec_wb = 2'b11;
            end
            OpAuipc: begin
                legal   = 1'b1;
                dec_src = 1'b1;
                dec_apc = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      state_d = StFetch;
            StFetch:     if (ifetch_ready) state_d = StDecode;
            StDecode: begin
                if (!legal)      state_d = StTrap;
                else if (is_mop) state_d = StMuldiv;
                else             state_d = StExecute;
            end
            StExecute: begin
                if (is_load || is_store) state_d = StMem;
                else if (is_branch)      state_d = StFetch;
                else                     state_d = StWriteback;
            end
            StMem:       if (dmem_ready) state_d = is_load ? StWriteback : StFetch;
            StWriteback: state_d = StFetch;
            StMuldiv:    if (muldiv_done) state_d = StWriteback;
            StTrap:      state_d = (TRAP_HALT != 0) ? StTrap : StFetch;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ir_q      <= Nop;
            ill_q     <= 1'b0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_busy_q <= (state_q == StMuldiv);
            if (state_q == StFetch && ifetch_ready) ir_q <= instr;
            if (state_d == StTrap) ill_q <= 1'b1;
        end
    end

    // Branch select and store completion follow the same-cycle handshake inputs.
    always_comb begin
        ifetch_req            = 1'b0;
        dmem_req              = 1'b0;
        dmem_we               = 1'b0;
        muldiv_start          = 1'b0;
        pc_write              = 1'b0;
        register_enable_write = 1'b0;
        retired               = 1'b0;
        muldiv_sel            = 1'b0;
        next_pc_select        = 2'b00;
        alu_control           = dec_alu;
        alu_src               = dec_src;
        alu_src_a_pc          = dec_apc;
        wb_select             = dec_wb;
        muldiv_op             = funct3;
        memory_size           = funct3[1:0];
        memory_sign_ext       = ~funct3[2];
        case (state_q)
            StIdle: begin
                alu_control     = 4'b0000;
                alu_src         = 1'b0;
                alu_src_a_pc    = 1'b0;
                wb_select       = 2'b00;
                muldiv_op       = 3'b000;
                memory_size     = 2'b10;
                memory_sign_ext = 1'b1;
            end
            StFetch: ifetch_req = 1'b1;
            StExecute: begin
                if (is_branch) begin
                    pc_write       = 1'b1;
                    retired        = 1'b1;
                    next_pc_select = {1'b0, branch_taken};
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (is_store && dmem_ready) begin
                    pc_write = 1'b1;
                    retired  = 1'b1;
                end
            end
            StWriteback: begin
                pc_write              = 1'b1;
                retired               = 1'b1;
                register_enable_write = (rd != 5'd0);
                muldiv_sel            = is_mop;
                if (is_jal)       next_pc_select = 2'b10;
                else if (is_jalr) next_pc_select = 2'b11;
            end
            StMuldiv: muldiv_start = !md_busy_q;
            StTrap:   pc_write = (TRAP_HALT == 0);
            default: ;
        endcase
    end

    assign illegal_instr = ill_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a spec-level instruction model predicts the
// per-cycle state path and control outputs for each fetched instruction.
module tb_multicycle_control_unit;

    localparam int ClAlu = 0, ClLd = 1, ClSt = 2, ClBr = 3, ClJal = 4, ClJalr = 5, ClOther = 6;

    typedef struct {
        bit         legal;
        bit         mop;
        int         cls;
        bit         chk_alu;
        logic [3:0] alu;
        bit         src;
        bit         apc;
        logic [1:0] wb;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst, ifetch_ready, dmem_ready, branch_taken, muldiv_done;
    logic [31:0] instr;
    logic        ifetch_req, dmem_req, dmem_we, muldiv_start, pc_write, reg_we;
    logic        alu_src, alu_src_a_pc, muldiv_sel, memory_sign_ext, illegal_instr, retired;
    logic [2:0]  muldiv_op, state;
    logic [3:0]  alu_control;
    logic [1:0]  wb_select, next_pc_select, memory_size;

    logic        b_rst, b_ifetch_ready;
    logic [31:0] b_instr;
    logic        b_ifetch_req, b_dmem_req, b_dmem_we, b_muldiv_start, b_pc_write, b_reg_we;
    logic        b_alu_src, b_alu_src_a_pc, b_muldiv_sel, b_sext, b_illegal, b_retired;
    logic [2:0]  b_muldiv_op, b_state;
    logic [3:0]  b_alu_control;
    logic [1:0]  b_wb_select, b_nps, b_memory_size;

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_ill = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ENABLE_M(1), .TRAP_HALT(0)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .ifetch_req(ifetch_req),
        .ifetch_ready(ifetch_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .muldiv_done(muldiv_done), .muldiv_op(muldiv_op), .pc_write(pc_write),
        .register_enable_write(reg_we), .alu_src(alu_src), .alu_src_a_pc(alu_src_a_pc),
        .alu_control(alu_control), .wb_select(wb_select), .muldiv_sel(muldiv_sel),
        .next_pc_select(next_pc_select), .memory_size(memory_size),
        .memory_sign_ext(memory_sign_ext), .illegal_instr(illegal_instr), .retired(retired),
        .state(state)
    );

    multicycle_control_unit u_dut_dflt (
        .clk(clk), .rst(b_rst), .instr(b_instr), .ifetch_req(b_ifetch_req),
        .ifetch_ready(b_ifetch_ready), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
        .dmem_ready(1'b0), .branch_taken(1'b0), .muldiv_start(b_muldiv_start),
        .muldiv_done(1'b0), .muldiv_op(b_muldiv_op), .pc_write(b_pc_write),
        .register_enable_write(b_reg_we), .alu_src(b_alu_src), .alu_src_a_pc(b_alu_src_a_pc),
        .alu_control(b_alu_control), .wb_select(b_wb_select), .muldiv_sel(b_muldiv_sel),
        .next_pc_select(b_nps), .memory_size(b_memory_size), .memory_sign_ext(b_sext),
        .illegal_instr(b_illegal), .retired(b_retired), .state(b_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        check_eq({tag, "_pc_write"}, 32'(pc_write), 32'd0);
        check_eq({tag, "_reg_we"}, 32'(reg_we), 32'd0);
        check_eq({tag, "_retired"}, 32'(retired), 32'd0);
        check_eq({tag, "_md_start"}, 32'(muldiv_start), 32'd0);
        check_eq({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    endtask

    // ALU code = base code of funct3, +1 for the SUB/SRA alternates
    function automatic ref_t ref_decode(input logic [31:0] ins, input bit en_m);
        ref_t       r;
        int         tab [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        r.legal = 0; r.mop = 0; r.cls = ClOther; r.chk_alu = 1;
        r.alu = 4'd0; r.src = 0; r.apc = 0; r.wb = 2'd0;
        case (op)
            7'h33: begin
                r.cls = ClAlu;
                if (f7 == 7'h00) begin
                    r.legal = 1; r.alu = 4'(tab[f3]);
                end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    r.legal = 1; r.alu = 4'(tab[f3] + 1);
                end else if (f7 == 7'h01 && en_m) begin
                    r.legal = 1; r.mop = 1;
                end
            end
            7'h13: begin
                r.cls = ClAlu; r.src = 1;
                if (f3 != 3'd1 && f3 != 3'd5) begin
                    r.legal = 1; r.alu = 4'(tab[f3]);
                end else if (f7 == 7'h00) begin
                    r.legal = 1; r.alu = 4'(tab[f3]);
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    r.legal = 1; r.alu = 4'(tab[f3] + 1);
                end
            end
            7'h03: begin
                r.cls = ClLd; r.src = 1; r.wb = 2'b01;
                r.legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                r.cls = ClSt; r.src = 1; r.legal = (f3 <= 3'd2);
            end
            7'h63: begin
                r.cls = ClBr; r.alu = 4'd1; r.legal = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6f: begin
                r.cls = ClJal; r.legal = 1; r.wb = 2'b10; r.chk_alu = 0;
            end
            7'h67: begin
                r.cls = ClJalr; r.src = 1; r.wb = 2'b10; r.legal = (f3 == 3'd0);
            end
            7'h37: begin
                r.legal = 1; r.wb = 2'b11; r.chk_alu = 0;
            end
            7'h17: begin
                r.legal = 1; r.src = 1; r.apc = 1;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [9];
        logic [6:0]  f7s [4];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        ins = $urandom();
        k = $urandom_range(0, 10);
        if (k < 9) ins[6:0] = ops[k];
        if (k <= 1 || k == 10) begin
            if (k == 10) ins[6:0] = 7'h33;
            f7s[3] = 7'($urandom());
            ins[31:25] = f7s[$urandom_range(0, 3)];
        end
        return ins;
    endfunction

    task automatic run_one(input logic [31:0] ins, input int fstall, input int mstall,
                           input int mdlat, input bit bt);
        ref_t r;
        bit   st;
        r  = ref_decode(ins, 1'b1);
        st = (r.cls == ClSt);
        for (int i = 0; i <= fstall; i++) begin
            ifetch_ready = (i == fstall);
            instr = (i == fstall) ? ins : $urandom();
            #1;
            check_eq("fetch_state", 32'(state), 32'd1);
            check_eq("fetch_req", 32'(ifetch_req), 32'd1);
            check_eq("sticky_illegal", 32'(illegal_instr), 32'(seen_ill));
            chk_quiet("fetch");
            @(negedge clk);
        end
        ifetch_ready = 1'b0;
        instr = $urandom();
        #1;
        check_eq("decode_state", 32'(state), 32'd2);
        chk_quiet("decode");
        @(negedge clk);
        if (!r.legal) begin
            #1;
            check_eq("trap_state", 32'(state), 32'd7);
            check_eq("trap_illegal", 32'(illegal_instr), 32'd1);
            check_eq("trap_pc_write", 32'(pc_write), 32'd1);
            check_eq("trap_nps", 32'(next_pc_select), 32'd0);
            check_eq("trap_retired", 32'(retired), 32'd0);
            check_eq("trap_reg_we", 32'(reg_we), 32'd0);
            seen_ill = 1'b1;
            @(negedge clk);
            return;
        end
        if (r.mop) begin
            for (int i = 0; i <= mdlat; i++) begin
                muldiv_done = (i == mdlat);
                #1;
                check_eq("md_state", 32'(state), 32'd6);
                check_eq("md_start", 32'(muldiv_start), 32'(i == 0));
                check_eq("md_op", 32'(muldiv_op), 32'(ins[14:12]));
                check_eq("md_pc_write", 32'(pc_write), 32'd0);
                check_eq("md_reg_we", 32'(reg_we), 32'd0);
                @(negedge clk);
            end
            muldiv_done = 1'b0;
        end else begin
            branch_taken = bt;
            #1;
            check_eq("exec_state", 32'(state), 32'd3);
            if (r.chk_alu) begin
                check_eq("exec_alu", 32'(alu_control), 32'(r.alu));
                check_eq("exec_src", 32'(alu_src), 32'(r.src));
                check_eq("exec_apc", 32'(alu_src_a_pc), 32'(r.apc));
            end
            if (r.cls == ClBr) begin
                check_eq("br_nps", 32'(next_pc_select), 32'({1'b0, bt}));
                check_eq("br_pc_write", 32'(pc_write), 32'd1);
                check_eq("br_retired", 32'(retired), 32'd1);
                check_eq("br_reg_we", 32'(reg_we), 32'd0);
                @(negedge clk);
                branch_taken = 1'b0;
                return;
            end
            chk_quiet("exec");
            @(negedge clk);
            branch_taken = 1'b0;
            if (r.cls == ClLd || st) begin
                for (int i = 0; i <= mstall; i++) begin
                    dmem_ready = (i == mstall);
                    #1;
                    check_eq("mem_state", 32'(state), 32'd4);
                    check_eq("mem_req", 32'(dmem_req), 32'd1);
                    check_eq("mem_we", 32'(dmem_we), 32'(st));
                    check_eq("mem_size", 32'(memory_size), 32'(ins[13:12]));
                    check_eq("mem_sext", 32'(memory_sign_ext), 32'(!ins[14]));
                    check_eq("mem_pc_write", 32'(pc_write), 32'(st && i == mstall));
                    check_eq("mem_retired", 32'(retired), 32'(st && i == mstall));
                    check_eq("mem_reg_we", 32'(reg_we), 32'd0);
                    @(negedge clk);
                end
                dmem_ready = 1'b0;
                if (st) return;
            end
        end
        #1;
        check_eq("wb_state", 32'(state), 32'd5);
        check_eq("wb_pc_write", 32'(pc_write), 32'd1);
        check_eq("wb_retired", 32'(retired), 32'd1);
        check_eq("wb_reg_we", 32'(reg_we), 32'(ins[11:7] != 5'd0));
        check_eq("wb_nps", 32'(next_pc_select),
                 (r.cls == ClJal) ? 32'd2 : (r.cls == ClJalr) ? 32'd3 : 32'd0);
        check_eq("wb_md_sel", 32'(muldiv_sel), 32'(r.mop));
        if (!r.mop) check_eq("wb_select", 32'(wb_select), 32'(r.wb));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ifetch_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        muldiv_done = 1'b0; instr = 32'd0;
        b_rst = 1'b1; b_ifetch_ready = 1'b1; b_instr = 32'h0220_8033;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("idle_state", 32'(state), 32'd0);
        check_eq("idle_size", 32'(memory_size), 32'd2);
        check_eq("idle_sext", 32'(memory_sign_ext), 32'd1);
        check_eq("idle_ifetch", 32'(ifetch_req), 32'd0);
        check_eq("idle_alu", 32'(alu_control), 32'd0);
        check_eq("idle_wb", 32'(wb_select), 32'd0);
        check_eq("idle_illegal", 32'(illegal_instr), 32'd0);
        chk_quiet("idle");
        rst = 1'b0;
        @(negedge clk);

        run_one(32'h0020_81B3, 0, 0, 0, 1'b0);  // ADD x3,x1,x2
        run_one(32'h0000_A083, 0, 3, 0, 1'b0);  // LW x1,0(x1)
        run_one(32'h0020_8063, 1, 0, 0, 1'b1);  // BEQ taken
        run_one(32'h0220_8033, 0, 0, 5, 1'b0);  // MUL
        run_one(32'h0220_8033, 2, 0, 0, 1'b0);  // MUL, done on first cycle
        run_one(32'h0020_A023, 0, 2, 0, 1'b0);  // SW
        run_one(32'h0080_00EF, 0, 0, 0, 1'b0);  // JAL
        run_one(32'h0000_80E7, 0, 0, 0, 1'b0);  // JALR
        for (int n = 0; n < 300; n++) begin
            run_one(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 5), 1'($urandom()));
        end
        run_one(32'hFFFF_FFFF, 0, 0, 0, 1'b0);

        // Reset during a stalled load
        ifetch_ready = 1'b1;
        instr = 32'h0000_A083;
        #1;
        check_eq("pre_rst_illegal", 32'(illegal_instr), 32'd1);
        @(negedge clk);
        ifetch_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("stall_state", 32'(state), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_illegal", 32'(illegal_instr), 32'd0);
        check_eq("rst_ifetch", 32'(ifetch_req), 32'd0);
        check_eq("rst_dmem_we", 32'(dmem_we), 32'd0);
        check_eq("rst_size", 32'(memory_size), 32'd2);
        check_eq("rst_sext", 32'(memory_sign_ext), 32'd1);
        chk_quiet("rst");
        seen_ill = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_rst_state", 32'(state), 32'd1);

        // Default parameters: M-op is illegal and the trap halts
        b_rst = 1'b0;
        #1;
        check_eq("dflt_idle", 32'(b_state), 32'd0);
        @(negedge clk);
        #1;
        check_eq("dflt_fetch", 32'(b_state), 32'd1);
        @(negedge clk);
        #1;
        check_eq("dflt_decode", 32'(b_state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("dflt_trap_state", 32'(b_state), 32'd7);
            check_eq("dflt_trap_illegal", 32'(b_illegal), 32'd1);
            check_eq("dflt_trap_pc_write", 32'(b_pc_write), 32'd0);
            check_eq("dflt_trap_retired", 32'(b_retired), 32'd0);
            check_eq("dflt_trap_md_start", 32'(b_muldiv_start), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
